conv_pixel_scheduler: RTL and testbench

- Sequences one conv layer over a shared pipelined filter unit, issuing one pixel job per cycle instead of one job per pipeline latency.
- Walks raster order (col fastest, then row, then filter) and drives the window/weight select coordinates and pipeline valid_in.
- Re-associates in-order pipeline results with their coordinates and hands them to the feature-map writer over a valid/ready port.
- Credit control keeps in-flight jobs plus buffered results at or below FIFO_DEPTH, so results are never dropped under writer backpressure.

---
 rtl/conv_sched_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/conv_pixel_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_conv_pixel_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// Shared types for the conv pixel scheduler: FSM states and the pixel coordinate tag.
// Tag fields are sized for the largest supported layer (32 filters, 14x14 map).
package conv_sched_pkg;

    localparam int unsigned MAX_FILTERS = 32;
    localparam int unsigned MAX_MAP_H   = 14;
    localparam int unsigned MAX_MAP_W   = 14;

    localparam int unsigned TAG_F_W   = $clog2(MAX_FILTERS);
    localparam int unsigned TAG_ROW_W = $clog2(MAX_MAP_H);
    localparam int unsigned TAG_COL_W = $clog2(MAX_MAP_W);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        HOLD
    } state_t;

    typedef struct packed {
        logic [TAG_F_W-1:0]   f;
        logic [TAG_ROW_W-1:0] row;
        logic [TAG_COL_W-1:0] col;
    } pix_tag_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push and pop on the same cycle while empty
// is not supported and must be prevented by the caller.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;

endmodule

// File: rtl/conv_pixel_scheduler.sv
// Issues one conv pixel job per cycle under credit control and re-tags in-order results.
// Optional watchdog (CONV_SCHED_WATCHDOG_EN) flushes stuck jobs with zero results.
module conv_pixel_scheduler
    import conv_sched_pkg::*;
#(
    parameter int unsigned NUM_FILTERS = 32,
    parameter int unsigned MAP_H       = 14,
    parameter int unsigned MAP_W       = 14,
    parameter int unsigned PIPE_LAT    = 18,
    parameter int unsigned FIFO_DEPTH  = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WD_CYCLES   = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    output logic                           done,
    output logic                           busy,
    output logic                           issue_valid,
    output logic [$clog2(NUM_FILTERS)-1:0] f_idx,
    output logic [$clog2(MAP_H)-1:0]       row,
    output logic [$clog2(MAP_W)-1:0]       col,
    input  logic                           pipe_valid_out,
    input  logic [DATA_W-1:0]              pipe_result,
    output logic                           wr_valid,
    input  logic                           wr_ready,
    output logic [$clog2(NUM_FILTERS)-1:0] wr_f,
    output logic [$clog2(MAP_H)-1:0]       wr_row,
    output logic [$clog2(MAP_W)-1:0]       wr_col,
    output logic [DATA_W-1:0]              wr_data,
    output logic                           err_orphan,
    output logic                           timeout
);

    localparam int unsigned F_W   = $clog2(NUM_FILTERS);
    localparam int unsigned ROW_W = $clog2(MAP_H);
    localparam int unsigned COL_W = $clog2(MAP_W);
    localparam int unsigned TOTAL = NUM_FILTERS * MAP_H * MAP_W;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);
    localparam int unsigned FC_W  = $clog2(FIFO_DEPTH + 1);

    state_t             state_q, state_d;
    logic [F_W-1:0]     f_q, f_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic [CNT_W-1:0]   written_q, written_d;
    logic               err_q;

    logic               issue_c, wr_fire_c, last_pix_c, pending_c, synth_c;
    logic               res_push_c, orphan_c;
    logic [DATA_W-1:0]  res_din_c;
    pix_tag_t           tag_in, tag_head;
    logic [FC_W-1:0]    tag_cnt, res_cnt;
    logic               res_empty;
    logic               tag_empty_unused, tag_full_unused, res_full_unused;
    logic               unused_cfg;
    logic               unused_tag_bits;

    // Outstanding = issued - written must stay below FIFO_DEPTH to grant a credit.
    assign issue_c    = (state_q == ISSUE) && (32'(issued_q - written_q) < FIFO_DEPTH);
    assign wr_fire_c  = !res_empty && wr_ready;
    assign last_pix_c = (f_q == F_W'(NUM_FILTERS - 1)) && (row_q == ROW_W'(MAP_H - 1))
                     && (col_q == COL_W'(MAP_W - 1));
    assign pending_c  = (tag_cnt > res_cnt);

    always_comb begin : fsm_next
        state_d   = state_q;
        f_d       = f_q;
        row_d     = row_q;
        col_d     = col_q;
        issued_d  = issued_q + CNT_W'(issue_c);
        written_d = written_q + CNT_W'(wr_fire_c);
        case (state_q)
            IDLE: begin
                f_d       = '0;
                row_d     = '0;
                col_d     = '0;
                issued_d  = '0;
                written_d = '0;
                if (start) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_c) begin
                    if (last_pix_c) begin
                        state_d = DRAIN;
                    end else if (col_q == COL_W'(MAP_W - 1)) begin
                        col_d = '0;
                        if (row_q == ROW_W'(MAP_H - 1)) begin
                            row_d = '0;
                            f_d   = f_q + F_W'(1);
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (written_d == CNT_W'(TOTAL)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A result with no tag awaiting it (or colliding with a flush slot) is dropped.
    assign res_push_c = synth_c || (pipe_valid_out && pending_c);
    assign orphan_c   = pipe_valid_out && (!pending_c || synth_c);
    assign res_din_c  = synth_c ? '0 : pipe_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            f_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            issued_q  <= '0;
            written_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            f_q       <= f_d;
            row_q     <= row_d;
            col_q     <= col_d;
            issued_q  <= issued_d;
            written_q <= written_d;
            err_q     <= err_q | orphan_c;
        end
    end

`ifdef CONV_SCHED_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WD_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q, timeout_d;

    // Once tripped, every tag still awaiting a result is answered with zero.
    assign synth_c = timeout_q && pending_c;

    always_comb begin : wd_next
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        if (pipe_valid_out) begin
            wd_cnt_d = '0;
        end else if (pending_c && !timeout_q) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
            if (wd_cnt_d == WD_W'(WD_CYCLES)) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign synth_c = 1'b0;
    assign timeout = 1'b0;
`endif

    assign tag_in = '{f: TAG_F_W'(f_q), row: TAG_ROW_W'(row_q), col: TAG_COL_W'(col_q)};

    sync_fifo #(.WIDTH($bits(pix_tag_t)), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (issue_c),
        .pop_i   (wr_fire_c),
        .din_i   (tag_in),
        .dout_o  (tag_head),
        .empty_o (tag_empty_unused),
        .full_o  (tag_full_unused),
        .count_o (tag_cnt)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_res_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (res_push_c),
        .pop_i   (wr_fire_c),
        .din_i   (res_din_c),
        .dout_o  (wr_data),
        .empty_o (res_empty),
        .full_o  (res_full_unused),
        .count_o (res_cnt)
    );

    assign unused_cfg      = (PIPE_LAT == 0) ^ (WD_CYCLES == 0);
    assign unused_tag_bits = ^tag_head;

    assign done        = (state_q == HOLD);
    assign busy        = (state_q == ISSUE) || (state_q == DRAIN);
    assign issue_valid = issue_c;
    assign f_idx       = f_q;
    assign row         = row_q;
    assign col         = col_q;
    assign wr_valid    = !res_empty;
    assign wr_f        = F_W'(tag_head.f);
    assign wr_row      = ROW_W'(tag_head.row);
    assign wr_col      = COL_W'(tag_head.col);
    assign err_orphan  = err_q;

endmodule

// File: tb/tb_conv_pixel_scheduler.sv
// Bench for conv_pixel_scheduler: two instances (credit depth 8 and 2) share stimulus;
// a latency-line pipeline returns f*100+row*10+col and writes are scored in raster order.
module tb_conv_pixel_scheduler;

    localparam int unsigned NF    = 2;
    localparam int unsigned MH    = 3;
    localparam int unsigned MW    = 3;
    localparam int unsigned PL    = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned WD    = 10;
    localparam int          TOTAL = NF * MH * MW;
    localparam int unsigned FW    = $clog2(NF);
    localparam int unsigned RW    = $clog2(MH);
    localparam int unsigned CWD   = $clog2(MW);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, wr_ready, stray;
    int   pipe_limit;

    logic          done_v [2];
    logic          busy_v [2];
    logic          iv_v   [2];
    logic [FW-1:0] fi_v   [2];
    logic [RW-1:0] ro_v   [2];
    logic [CWD-1:0] co_v  [2];
    logic          pvo_v  [2];
    logic [DW-1:0] pres_v [2];
    logic          wrv_v  [2];
    logic [FW-1:0] wf_v   [2];
    logic [RW-1:0] wro_v  [2];
    logic [CWD-1:0] wco_v [2];
    logic [DW-1:0] wd_v   [2];
    logic          err_v  [2];
    logic          tmo_v  [2];

    conv_pixel_scheduler #(.NUM_FILTERS(NF), .MAP_H(MH), .MAP_W(MW), .PIPE_LAT(PL),
                           .FIFO_DEPTH(8), .DATA_W(DW), .WD_CYCLES(WD)) u_dut_a (
        .clk(clk), .reset(reset), .start(start), .done(done_v[0]), .busy(busy_v[0]),
        .issue_valid(iv_v[0]), .f_idx(fi_v[0]), .row(ro_v[0]), .col(co_v[0]),
        .pipe_valid_out(pvo_v[0]), .pipe_result(pres_v[0]), .wr_valid(wrv_v[0]),
        .wr_ready(wr_ready), .wr_f(wf_v[0]), .wr_row(wro_v[0]), .wr_col(wco_v[0]),
        .wr_data(wd_v[0]), .err_orphan(err_v[0]), .timeout(tmo_v[0])
    );

    conv_pixel_scheduler #(.NUM_FILTERS(NF), .MAP_H(MH), .MAP_W(MW), .PIPE_LAT(PL),
                           .FIFO_DEPTH(2), .DATA_W(DW), .WD_CYCLES(WD)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .done(done_v[1]), .busy(busy_v[1]),
        .issue_valid(iv_v[1]), .f_idx(fi_v[1]), .row(ro_v[1]), .col(co_v[1]),
        .pipe_valid_out(pvo_v[1]), .pipe_result(pres_v[1]), .wr_valid(wrv_v[1]),
        .wr_ready(wr_ready), .wr_f(wf_v[1]), .wr_row(wro_v[1]), .wr_col(wco_v[1]),
        .wr_data(wd_v[1]), .err_orphan(err_v[1]), .timeout(tmo_v[1])
    );

    // Fixed-latency pipeline; stops producing results after pipe_limit jobs.
    logic          pv [2][PL];
    logic [DW-1:0] pd [2][PL];
    int            sent [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                for (int i = 0; i < int'(PL); i++) begin
                    pv[d][i] <= 1'b0;
                    pd[d][i] <= '0;
                end
                sent[d] <= 0;
            end else begin
                for (int i = int'(PL) - 1; i > 0; i--) begin
                    pv[d][i] <= pv[d][i-1];
                    pd[d][i] <= pd[d][i-1];
                end
                pv[d][0] <= iv_v[d] && (sent[d] < pipe_limit);
                pd[d][0] <= 32'(fi_v[d]) * 100 + 32'(ro_v[d]) * 10 + 32'(co_v[d]);
                if (iv_v[d]) sent[d] <= sent[d] + 1;
            end
        end
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            pvo_v[d]  = pv[d][PL-1] | stray;
            pres_v[d] = pd[d][PL-1];
        end
    end

    int total = 0;
    int bad   = 0;
    int sel, cyc, n_iss, n_wr, first_iss, last_iss, last_wr_cyc, done_cyc;
    int burst, max_burst, exp_real;
    bit done_seen, rate_chk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int depth_of(input int d);
        return (d == 0) ? 8 : 2;
    endfunction

    task automatic reset_mon();
        n_iss = 0; n_wr = 0; first_iss = -1; last_iss = -1;
        last_wr_cyc = -100; done_cyc = -1; done_seen = 0; burst = 0; max_burst = 0;
    endtask

    // Sample the selected instance mid-cycle, score it, then advance one clock.
    task automatic tick();
        int exp_d;
        #1;
        if (rate_chk && n_iss < TOTAL)
            chk("credit_rule", 64'(iv_v[sel]), 64'((n_iss - n_wr) < depth_of(sel)));
        if (iv_v[sel]) begin
            chk("issue_f",   64'(fi_v[sel]), 64'(n_iss / (MH * MW)));
            chk("issue_row", 64'(ro_v[sel]), 64'((n_iss / MW) % MH));
            chk("issue_col", 64'(co_v[sel]), 64'(n_iss % MW));
            if (n_iss == 0) first_iss = cyc;
            last_iss = cyc;
            n_iss++;
            burst++;
            if (burst > max_burst) max_burst = burst;
        end else begin
            burst = 0;
        end
        if (wrv_v[sel] && wr_ready) begin
            exp_d = (n_wr / (MH * MW)) * 100 + ((n_wr / MW) % MH) * 10 + (n_wr % MW);
            if (n_wr >= exp_real) exp_d = 0;
            chk("wr_f",    64'(wf_v[sel]),  64'(n_wr / (MH * MW)));
            chk("wr_row",  64'(wro_v[sel]), 64'((n_wr / MW) % MH));
            chk("wr_col",  64'(wco_v[sel]), 64'(n_wr % MW));
            chk("wr_data", 64'(wd_v[sel]),  64'(exp_d));
            n_wr++;
            last_wr_cyc = cyc;
        end
        if (done_v[sel] && !done_seen) begin
            done_seen = 1;
            done_cyc  = cyc;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_reset_outputs(input int d);
        #1;
        chk("rst_done",  64'(done_v[d]), 0);
        chk("rst_busy",  64'(busy_v[d]), 0);
        chk("rst_issue", 64'(iv_v[d]),   0);
        chk("rst_wrv",   64'(wrv_v[d]),  0);
        chk("rst_err",   64'(err_v[d]),  0);
        chk("rst_tmo",   64'(tmo_v[d]),  0);
        chk("rst_f",     64'(fi_v[d]),   0);
        chk("rst_row",   64'(ro_v[d]),   0);
        chk("rst_col",   64'(co_v[d]),   0);
    endtask

    // Start a layer and run it to done; hold>0 keeps the writer stalled that many cycles.
    task automatic run_layer(input int hold, input int budget);
        reset_mon();
        start = 1'b1;
        if (hold > 0) wr_ready = 1'b0;
        tick();
        rate_chk = 1;
        for (int k = 1; k < budget && !done_seen; k++) begin
            if (hold > 0 && k == hold) begin
                chk("held_issues",   64'(n_iss), 64'(depth_of(sel)));
                chk("held_no_issue", 64'(iv_v[sel]), 0);
                wr_ready = 1'b1;
            end
            tick();
        end
        rate_chk = 0;
        chk("done_reached", 64'(done_seen), 1);
        chk("n_issued",     64'(n_iss), 64'(TOTAL));
        chk("n_written",    64'(n_wr),  64'(TOTAL));
        chk("done_latency", 64'(done_cyc), 64'(last_wr_cyc + 1));
        chk("no_orphan",    64'(err_v[sel]), 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; wr_ready = 1'b1; stray = 1'b0;
        pipe_limit = 1 << 20; exp_real = 1 << 20;
        sel = 0; cyc = 0; rate_chk = 0;
        reset_mon();
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        check_reset_outputs(0);
        check_reset_outputs(1);

        // Free-flowing writer: back-to-back issue, in-order writes.
        run_layer(0, 200);
        chk("issue_span", 64'(last_iss - first_iss), 64'(TOTAL - 1));

        // Start held high after completion must not restart.
        for (int k = 0; k < 5; k++) tick();
        chk("hold_done",     64'(done_v[0]), 1);
        chk("hold_not_busy", 64'(busy_v[0]), 0);
        chk("hold_no_issue", 64'(n_iss), 64'(TOTAL));
        start = 1'b0;
        tick();
        chk("idle_done_low", 64'(done_v[0]), 0);
        chk("idle_not_busy", 64'(busy_v[0]), 0);

        // Restart from IDLE with the writer stalled for 30 cycles.
        run_layer(30, 300);

        // Reset in the middle of issuing, then a stray pipeline result.
        start = 1'b0;
        tick();
        reset_mon();
        start = 1'b1;
        for (int k = 0; k < 50 && n_iss < 5; k++) tick();
        chk("five_issued", 64'(n_iss), 5);
        reset = 1'b1;
        start = 1'b0;
        tick();
        reset = 1'b0;
        check_reset_outputs(0);
        stray = 1'b1;
        tick();
        stray = 1'b0;
        #1;
        chk("orphan_set",     64'(err_v[0]), 1);
        chk("orphan_dropped", 64'(wrv_v[0]), 0);

        // Depth-2 instance: throttled issue, still correct.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sel = 1;
        run_layer(0, 300);
        chk("burst_max", 64'(max_burst), 2);
        chk("throttled", 64'((last_iss - first_iss) > TOTAL - 1), 1);
        chk("no_timeout", 64'(tmo_v[1]), 0);

`ifdef CONV_SCHED_WATCHDOG_EN
        // Pipeline goes silent after 5 results; remaining pixels complete as zeros.
        start = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sel = 0;
        pipe_limit = 5;
        exp_real = 5;
        run_layer(0, 600);
        chk("timeout_set", 64'(tmo_v[0]), 1);
        pipe_limit = 1 << 20;
        exp_real = 1 << 20;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
